// File: rtl/cam_rgb565_capture.sv
// OV7670 RGB565 byte-stream capture, packing to RGB332 and writing y*X+x into the frame buffer.
// Optional build macro CAPTURE_TEST_PATTERN_EN replaces pixel data with four colour bars derived from x.
module cam_rgb565_capture #(
   parameter int CAM_SCREEN_X = 320,
   parameter int CAM_SCREEN_Y = 240,
   parameter int AW           = 17,
   parameter int DW           = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cam_vsync,
   input  logic          cam_href,
   input  logic [7:0]    cam_data,
   input  logic          capture_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   output logic          mem_we,
   output logic          frame_done,
   output logic          capture_busy,
   output logic          overflow
);

   localparam int CW = 10;
   localparam logic [CW-1:0] X_LIM  = CW'(CAM_SCREEN_X);
   localparam logic [CW-1:0] Y_LIM  = CW'(CAM_SCREEN_Y);
   localparam logic [AW-1:0] X_STEP = AW'(CAM_SCREEN_X);

   typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DONE} state_t;

   state_t        state;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic [AW-1:0] line_base;
   logic          phase;
   logic          href_p0;
   logic [5:0]    byte0_p0;
   logic [DW-1:0] pixel;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

`ifdef CAPTURE_TEST_PATTERN_EN
   localparam logic [CW-1:0] BAR1 = CW'(CAM_SCREEN_X / 4);
   localparam logic [CW-1:0] BAR2 = CW'(CAM_SCREEN_X / 2);
   localparam logic [CW-1:0] BAR3 = CW'((3 * CAM_SCREEN_X) / 4);

   function automatic logic [DW-1:0] bar_colour(input logic [CW-1:0] xp);
      if (xp < BAR1)      return DW'(8'hE0);
      else if (xp < BAR2) return DW'(8'h1C);
      else if (xp < BAR3) return DW'(8'h03);
      else                return DW'(8'hFF);
   endfunction

   assign pixel = bar_colour(x);
`else
   // byte0 is stored pre-trimmed to R[7:5] and G-high[2:0]; byte1 contributes B[4:3]
   function automatic logic [DW-1:0] pack_pixel(input logic [5:0] b0, input logic [1:0] b1);
      return DW'({b0, b1});
   endfunction

   assign pixel = pack_pixel(byte0_p0, cam_data[4:3]);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         x            <= '0;
         y            <= '0;
         line_base    <= '0;
         phase        <= 1'b0;
         href_p0      <= 1'b0;
         byte0_p0     <= '0;
         mem_addr     <= '0;
         mem_data     <= '0;
         mem_we       <= 1'b0;
         frame_done   <= 1'b0;
         capture_busy <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         mem_we       <= 1'b0;
         frame_done   <= 1'b0;
         capture_busy <= (state == SYNC) || (state == ACTIVE);
         case (state)
            IDLE: begin
               href_p0 <= 1'b0;
               if (capture_en && cam_vsync) state <= SYNC;
            end
            SYNC: begin
               x         <= '0;
               y         <= '0;
               line_base <= '0;
               phase     <= 1'b0;
               href_p0   <= 1'b0;
               overflow  <= 1'b0;
               if (!cam_vsync) state <= ACTIVE;
            end
            ACTIVE: begin
               // any VSYNC high here is a rise, since ACTIVE is only entered with VSYNC low
               if (cam_vsync) begin
                  phase <= 1'b0;
                  state <= DONE;
               end else begin
                  href_p0 <= cam_href;
                  if (cam_href) begin
                     if (!phase) begin
                        byte0_p0 <= {cam_data[7:5], cam_data[2:0]};
                        phase    <= 1'b1;
                     end else begin
                        phase <= 1'b0;
                        x     <= sat_inc(x);
                        if (x < X_LIM && y < Y_LIM) begin
                           mem_we   <= 1'b1;
                           mem_addr <= line_base + AW'(x);
                           mem_data <= pixel;
                        end else begin
                           overflow <= 1'b1;
                        end
                     end
                  end else if (href_p0) begin
                     phase <= 1'b0;
                     if (x != '0) begin
                        y <= sat_inc(y);
                        if (y < Y_LIM) line_base <= line_base + X_STEP;
                     end
                     x <= '0;
                  end
               end
            end
            DONE: begin
               frame_done <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Bench for cam_rgb565_capture on a reduced 40x6 geometry; expected writes are queued as bytes are driven.
// Honours CAPTURE_TEST_PATTERN_EN for the expected pixel value.
module tb_cam_rgb565_capture;

   localparam int TX = 40;
   localparam int TY = 6;
   localparam int AW = 17;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cam_vsync = 1'b0;
   logic          cam_href = 1'b0;
   logic [7:0]    cam_data = 8'h00;
   logic          capture_en = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_we;
   logic          frame_done;
   logic          capture_busy;
   logic          overflow;

   int total = 0;
   int bad = 0;
   int wr_count = 0;
   int exp_wr = 0;
   int fd_count = 0;
   logic [AW-1:0] last_addr = '0;
   logic [AW+DW-1:0] sb[$];
   int mx = 0;
   int my = 0;
   bit cap = 1'b0;

   cam_rgb565_capture #(
      .CAM_SCREEN_X(TX),
      .CAM_SCREEN_Y(TY),
      .AW(AW),
      .DW(DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cam_vsync(cam_vsync),
      .cam_href(cam_href),
      .cam_data(cam_data),
      .capture_en(capture_en),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .mem_we(mem_we),
      .frame_done(frame_done),
      .capture_busy(capture_busy),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      if (frame_done) fd_count++;
      if (mem_we) begin
         wr_count++;
         last_addr = mem_addr;
         total++;
         if (sb.size() > 0) e = sb.pop_front();
         else e = {(AW+DW){1'bx}};
         assert ({mem_addr, mem_data} === e)
         else begin
            bad++;
            $error("FAIL write got=%h exp=%h", {mem_addr, mem_data}, e);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] expd(input logic [7:0] b0, input logic [7:0] b1, input int xp);
`ifdef CAPTURE_TEST_PATTERN_EN
      if (xp < TX / 4) return 8'hE0;
      else if (xp < TX / 2) return 8'h1C;
      else if (xp < (3 * TX) / 4) return 8'h03;
      else return 8'hFF;
`else
      return {b0[7:5], b0[2:0], b1[4:3]};
`endif
   endfunction

   task automatic pix(input logic [7:0] b0, input logic [7:0] b1);
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = b0;
      @(negedge clk);
      cam_data = b1;
      if (cap && mx < TX && my < TY) begin
         sb.push_back({AW'(my * TX + mx), expd(b0, b1, mx)});
         exp_wr++;
      end
      mx++;
   endtask

   task automatic odd_byte(input logic [7:0] b);
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = b;
   endtask

   task automatic rand_line(input int n);
      repeat (n) pix(8'($urandom), 8'($urandom));
   endtask

   task automatic end_line();
      @(negedge clk);
      cam_href = 1'b0;
      cam_data = 8'($urandom);
      if (mx > 0) my++;
      mx = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic start_frame();
      @(negedge clk);
      cam_vsync = 1'b1;
      @(negedge clk);
      @(negedge clk);
      cam_vsync = 1'b0;
      mx = 0;
      my = 0;
   endtask

   task automatic end_frame_chk(input string tag);
      @(negedge clk);
      cam_href = 1'b0;
      cam_vsync = 1'b1;
      @(negedge clk);
      chk({tag, "_fd_m"}, 32'(frame_done), 0);
      chk({tag, "_busy_m"}, 32'(capture_busy), 1);
      @(negedge clk);
      chk({tag, "_fd_pulse"}, 32'(frame_done), 1);
      chk({tag, "_busy_low"}, 32'(capture_busy), 0);
      @(negedge clk);
      chk({tag, "_fd_end"}, 32'(frame_done), 0);
   endtask

   initial begin
      // reset held while inputs toggle
      repeat (5) begin
         @(negedge clk);
         cam_vsync = 1'($urandom);
         cam_href = 1'($urandom);
         cam_data = 8'($urandom);
         capture_en = 1'($urandom);
         #1;
         chk("reset_outs", 32'({mem_addr, mem_data, mem_we, frame_done, capture_busy, overflow}), 0);
      end
      @(negedge clk);
      rst = 1'b1;
      capture_en = 1'b1;
      cam_vsync = 1'b0;
      cam_href = 1'b0;
      cap = 1'b0;
      rand_line(4);
      end_line();
      idle(3);
      chk("no_write_before_vsync", 32'(wr_count), 0);
      chk("idle_busy", 32'(capture_busy), 0);

      // frame 1: packing then a clean full frame
      cap = 1'b1;
      start_frame();
      pix(8'hF8, 8'h00);
      pix(8'h07, 8'hE0);
      pix(8'h00, 8'h1F);
      rand_line(TX - 3);
      end_line();
      idle(1);
      chk("busy_active", 32'(capture_busy), 1);
      for (int l = 1; l < TY; l++) begin
         rand_line(TX);
         end_line();
      end
      idle(2);
      chk("full_overflow", 32'(overflow), 0);
      chk("full_count", 32'(wr_count), TX * TY);
      chk("full_last_addr", 32'(last_addr), TX * TY - 1);
      end_frame_chk("f1");
      chk("f1_fd_count", 32'(fd_count), 1);

      // frame 2: overlong line, odd byte, empty line, VSYNC mid-pixel
      start_frame();
      rand_line(TX + 1);
      pix(8'($urandom), 8'($urandom));
      odd_byte(8'($urandom));
      end_line();
      idle(2);
      chk("ovf_count", 32'(wr_count), TX * TY + TX);
      chk("ovf_flag", 32'(overflow), 1);
      rand_line(TX);
      end_line();
      odd_byte(8'($urandom));
      end_line();
      rand_line(5);
      odd_byte(8'($urandom));
      capture_en = 1'b0;
      end_frame_chk("f2");
      idle(1);
      chk("f2_last_addr", 32'(last_addr), 2 * TX + 4);
      chk("f2_count", 32'(wr_count), exp_wr);

      // frame 3: capture disabled
      cap = 1'b0;
      start_frame();
      rand_line(5);
      end_line();
      idle(3);
      chk("disabled_count", 32'(wr_count), exp_wr);
      chk("disabled_busy", 32'(capture_busy), 0);
      chk("disabled_ovf_sticky", 32'(overflow), 1);

      // frame 4: SYNC clears overflow, then reset mid-line
      capture_en = 1'b1;
      cap = 1'b1;
      start_frame();
      idle(1);
      chk("sync_clears_ovf", 32'(overflow), 0);
      pix(8'($urandom), 8'($urandom));
      pix(8'($urandom), 8'($urandom));
      odd_byte(8'($urandom));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midreset_outs", 32'({mem_addr, mem_data, mem_we, frame_done, capture_busy, overflow}), 0);
      @(negedge clk);
      rst = 1'b1;
      cam_href = 1'b0;
      cap = 1'b0;
      rand_line(3);
      end_line();
      idle(3);
      chk("after_reset_no_write", 32'(wr_count), exp_wr);

      // frame 5: normal capture resumes at address 0
      cap = 1'b1;
      start_frame();
      pix(8'hF8, 8'h00);
      pix(8'h00, 8'h1F);
      end_line();
      idle(2);
      chk("f5_last_addr", 32'(last_addr), 1);
      end_frame_chk("f5");

      idle(2);
      chk("final_count", 32'(wr_count), exp_wr);
      chk("sb_empty", 32'(sb.size()), 0);
      chk("final_fd_count", 32'(fd_count), 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
